bit_serializer: RTL and testbench

Parallel-to-serial feeder for the serial sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single registered line. That line connects directly to the detector's `inp`, which samples every clock. A one-word holding buffer lets consecutive words stream with no idle gap between them.

---
 rtl/bit_serializer.sv | 131 +++++++++++++
 tb/tb_bit_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: takes WIDTH-bit words over valid/ready and emits them
// one bit per clock on a registered line, with a one-word holding buffer for gapless streaming.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             outp,
    output logic             busy,
    output logic             frame_done,
    output logic             dbg_state
);

    // Handshake: a word moves on any rising edge where load_valid && load_ready;
    // load_ready depends only on registered state and reset, never on load_valid.

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             outp_q, outp_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;

    // sreg keeps only the bits not yet driven, so the next bit is always at the same end.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] rest_bits(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = !hold_full_q && !reset;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        outp_d      = outp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    outp_d  = first_bit(data_in);
                    sreg_d  = rest_bits(data_in);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    if (hold_full_q) begin
                        outp_d      = first_bit(hold_q);
                        sreg_d      = rest_bits(hold_q);
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (accept) begin
                        outp_d = first_bit(data_in);
                        sreg_d = rest_bits(data_in);
                        cnt_d  = '0;
                    end else begin
                        outp_d  = IDLE_BIT;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    outp_d = first_bit(sreg_q);
                    sreg_d = rest_bits(sreg_q);
                    cnt_d  = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                outp_d  = IDLE_BIT;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d       = (state_d == SHIFT);
        frame_done_d = (state_d == SHIFT) && (cnt_d == LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            outp_q       <= IDLE_BIT;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            outp_q       <= outp_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign outp       = outp_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first 8-bit instance and an LSB-first 4-bit instance.
module tb_bit_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       outp;
    logic       busy;
    logic       frame_done;
    logic       dbg_state;

    logic [3:0] l_data_in;
    logic       l_load_valid;
    logic       l_load_ready;
    logic       l_outp;
    logic       l_busy;
    logic       l_frame_done;
    logic       l_dbg_state;

    int total;
    int bad;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .outp       (outp),
        .busy       (busy),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .data_in    (l_data_in),
        .load_valid (l_load_valid),
        .load_ready (l_load_ready),
        .outp       (l_outp),
        .busy       (l_busy),
        .frame_done (l_frame_done),
        .dbg_state  (l_dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    logic [15:0] exp3;
    logic [31:0] exp6;
    logic [3:0]  exp4;
    logic [7:0]  exp2;
    logic        rdy6;

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        data_in      = 8'h00;
        load_valid   = 1'b0;
        l_data_in    = 4'h0;
        l_load_valid = 1'b0;

        // 1: asynchronous reset between edges
        #20;
        reset = 1'b1;
        #1;
        chk("rst_outp", 32'(outp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        step();
        chk("rst_ready_held", 32'(load_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(load_ready), 32'd1);
        step();
        chk("rel_outp", 32'(outp), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        // 2: single word A5, MSB first
        exp2       = 8'hA5;
        data_in    = 8'hA5;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk("t2_outp", 32'(outp), 32'(exp2[7-k]));
            chk("t2_fdone", 32'(frame_done), (k == 7) ? 32'd1 : 32'd0);
            chk("t2_busy", 32'(busy), 32'd1);
        end
        step();
        chk("t2_idle_outp", 32'(outp), 32'd0);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_idle_fdone", 32'(frame_done), 32'd0);

        // 3: back-to-back through the holding register
        exp3       = 16'b11110000_00001111;
        data_in    = 8'hF0;
        load_valid = 1'b1;
        step();
        chk("t3_outp", 32'(outp), 32'(exp3[15]));
        chk("t3_ready0", 32'(load_ready), 32'd1);
        chk("t3_fdone", 32'(frame_done), 32'd0);
        data_in = 8'h0F;
        for (int k = 1; k < 16; k++) begin
            step();
            if (k == 1) load_valid = 1'b0;
            chk("t3_outp", 32'(outp), 32'(exp3[15-k]));
            chk("t3_fdone", 32'(frame_done), (k == 7 || k == 15) ? 32'd1 : 32'd0);
            chk("t3_busy", 32'(busy), 32'd1);
            chk("t3_ready", 32'(load_ready), (k >= 1 && k <= 7) ? 32'd0 : 32'd1);
        end
        step();
        chk("t3_idle_outp", 32'(outp), 32'd0);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // 4: LSB-first, WIDTH=4
        exp4         = 4'b0001;
        l_data_in    = 4'b0001;
        l_load_valid = 1'b1;
        step();
        l_load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk("t4_outp", 32'(l_outp), 32'(exp4[k]));
            chk("t4_fdone", 32'(l_frame_done), (k == 3) ? 32'd1 : 32'd0);
            chk("t4_busy", 32'(l_busy), 32'd1);
        end
        step();
        chk("t4_idle_outp", 32'(l_outp), 32'd0);
        chk("t4_idle_busy", 32'(l_busy), 32'd0);

        // 5: reset mid-frame with a held word
        data_in    = 8'hFF;
        load_valid = 1'b1;
        step();
        data_in = 8'h00;
        step();
        load_valid = 1'b0;
        chk("t5_ready_full", 32'(load_ready), 32'd0);
        step();
        chk("t5_outp_mid", 32'(outp), 32'd1);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_outp", 32'(outp), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(load_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t5_rel_ready", 32'(load_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t5_no_resume_outp", 32'(outp), 32'd0);
            chk("t5_no_resume_busy", 32'(busy), 32'd0);
            chk("t5_no_resume_fdone", 32'(frame_done), 32'd0);
        end

        // 6: acceptance at the boundary edge, then a stalled offer
        exp6       = {8'h3C, 8'h81, 8'h66, 8'h99};
        data_in    = 8'h3C;
        load_valid = 1'b1;
        step();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) step();
            rdy6 = !((k >= 9 && k <= 15) || (k >= 17 && k <= 23));
            chk("t6_outp", 32'(outp), 32'(exp6[31-k]));
            chk("t6_fdone", 32'(frame_done), (k % 8 == 7) ? 32'd1 : 32'd0);
            chk("t6_busy", 32'(busy), 32'd1);
            chk("t6_ready", 32'(load_ready), 32'(rdy6));
            if (k == 0) load_valid = 1'b0;
            if (k == 7) begin
                data_in    = 8'h81;
                load_valid = 1'b1;
            end
            if (k == 8) data_in = 8'h66;
            if (k == 9) data_in = 8'h99;
            if (k == 17) load_valid = 1'b0;
        end
        step();
        chk("t6_idle_outp", 32'(outp), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_ready", 32'(load_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
